// File: rtl/axi_pkg.sv
// Shared AXI encodings and channel FSM state types for the slave memory.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/axi_burst_addr.sv
// Burst address walker: latches a burst on load, steps per beat, reports word index and flags.
// With LOOKAHEAD=1 the outputs describe the beat that becomes current after this edge.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    STRB_WIDTH = 8,
  parameter int                    LEN_WIDTH  = 4,
  parameter int                    SIZE_WIDTH = 3,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter bit                    LOOKAHEAD  = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_i,
  input  logic [ADDR_WIDTH-1:0]        addr_i,
  input  logic [LEN_WIDTH-1:0]         len_i,
  input  logic [1:0]                   burst_i,
  input  logic [SIZE_WIDTH-1:0]        size_i,
  input  logic                         step_i,
  output logic [$clog2(MEM_DEPTH)-1:0] word_idx_o,
  output logic                         in_range_o,
  output logic                         last_o,
  output logic                         err_o
);

  localparam int OFF_W = $clog2(STRB_WIDTH);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_WIDTH);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d, v_addr, offset;
  logic [LEN_WIDTH-1:0]  len_q, len_d, cnt_q, cnt_d, v_len, v_cnt;
  logic                  incr_q, incr_d, bad_q, bad_d, v_bad;

  always_comb begin
    addr_d = addr_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    incr_d = incr_q;
    bad_d  = bad_q;
    if (load_i) begin
      addr_d = addr_i;
      len_d  = len_i;
      cnt_d  = '0;
      incr_d = (burst_i == BURST_INCR);
      // WRAP and the reserved encoding are rejected for every beat
      bad_d  = !((burst_i == BURST_INCR) || (burst_i == BURST_FIXED)) ||
               (size_i != SIZE_WIDTH'(OFF_W));
    end else if (step_i) begin
      cnt_d = cnt_q + LEN_WIDTH'(1);
      if (incr_q) addr_d = addr_q + ADDR_WIDTH'(STRB_WIDTH);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      incr_q <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      incr_q <= incr_d;
      bad_q  <= bad_d;
    end
  end

  assign v_addr = LOOKAHEAD ? addr_d : addr_q;
  assign v_len  = LOOKAHEAD ? len_d  : len_q;
  assign v_cnt  = LOOKAHEAD ? cnt_d  : cnt_q;
  assign v_bad  = LOOKAHEAD ? bad_d  : bad_q;

  // Low offset bits are dropped, so unaligned starts behave as aligned
  assign offset     = v_addr - BASE_ADDR;
  assign word_idx_o = offset[OFF_W +: IDX_W];
  assign in_range_o = (v_addr >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
  assign last_o     = (v_cnt == v_len);
  assign err_o      = v_bad;

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave memory with independent read and write channel FSMs over a two-port word array.
//   state  | meaning
//   W_IDLE | AWREADY high, waiting for a write address
//   W_DATA | WREADY high, accepting LEN+1 data beats
//   W_RESP | BVALID high, holding the response until BREADY
//   R_IDLE | ARREADY high, waiting for a read address
//   R_DATA | RVALID high, streaming LEN+1 beats
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    STRB_WIDTH = 8,
  parameter int                    LEN_WIDTH  = 4,
  parameter int                    SIZE_WIDTH = 3,
  parameter int                    ID_WIDTH   = 1,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [LEN_WIDTH-1:0]    AWLEN,
  input  logic [SIZE_WIDTH-1:0]   AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [STRB_WIDTH*8-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0]   WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  output logic                    BUSER,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [LEN_WIDTH-1:0]    ARLEN,
  input  logic [SIZE_WIDTH-1:0]   ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [STRB_WIDTH*8-1:0] RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  output logic                    RUSER,
  input  logic                    RREADY
);

  localparam int DATA_W = STRB_WIDTH * 8;
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  w_state_t          w_state_q, w_state_d;
  logic              awready_q, wready_q, bvalid_q, wflag_q;
  logic [ID_WIDTH-1:0] bid_q;
  logic [1:0]        bresp_q;
  logic              aw_hs, w_hs, b_hs;
  logic [IDX_W-1:0]  w_idx;
  logic              w_in_range, w_last, w_err, w_bad, w_beat_err;

  r_state_t          r_state_q, r_state_d;
  logic              arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0] rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              ar_hs, r_hs, r_step, r_load;
  logic [IDX_W-1:0]  r_idx;
  logic              r_in_range, r_last, r_err, r_bad;

  assign aw_hs = AWVALID & awready_q;
  assign w_hs  = WVALID & wready_q;
  assign b_hs  = BREADY & bvalid_q;
  assign ar_hs = ARVALID & arready_q;
  assign r_hs  = RREADY & rvalid_q;

  axi_burst_addr #(
    .ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH), .LEN_WIDTH(LEN_WIDTH),
    .SIZE_WIDTH(SIZE_WIDTH), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR), .LOOKAHEAD(1'b0)
  ) u_waddr (
    .clk(clk), .rst(rst), .load_i(aw_hs), .addr_i(AWADDR), .len_i(AWLEN),
    .burst_i(AWBURST), .size_i(AWSIZE), .step_i(w_hs),
    .word_idx_o(w_idx), .in_range_o(w_in_range), .last_o(w_last), .err_o(w_err)
  );

  // The read walker looks one beat ahead so RDATA can be registered on the advancing edge
  axi_burst_addr #(
    .ADDR_WIDTH(ADDR_WIDTH), .STRB_WIDTH(STRB_WIDTH), .LEN_WIDTH(LEN_WIDTH),
    .SIZE_WIDTH(SIZE_WIDTH), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR), .LOOKAHEAD(1'b1)
  ) u_raddr (
    .clk(clk), .rst(rst), .load_i(ar_hs), .addr_i(ARADDR), .len_i(ARLEN),
    .burst_i(ARBURST), .size_i(ARSIZE), .step_i(r_step),
    .word_idx_o(r_idx), .in_range_o(r_in_range), .last_o(r_last), .err_o(r_err)
  );

  assign w_bad      = w_err | ~w_in_range;
  assign w_beat_err = w_bad | (WLAST != w_last);

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_last) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      wflag_q   <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= (w_state_d == W_IDLE);
      wready_q  <= (w_state_d == W_DATA);
      bvalid_q  <= (w_state_d == W_RESP);
      if (aw_hs) begin
        bid_q   <= AWID;
        wflag_q <= 1'b0;
      end else if (w_hs && w_beat_err) begin
        wflag_q <= 1'b1;
      end
      if (w_hs && w_last) bresp_q <= (wflag_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !w_bad) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (WSTRB[i]) mem_q[w_idx][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
  end

  assign r_step = r_hs & ~rlast_q;
  assign r_load = ar_hs | r_step;
  assign r_bad  = r_err | ~r_in_range;

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_hs && rlast_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= (r_state_d == R_IDLE);
      if (ar_hs) rid_q <= ARID;
      if (r_load) begin
        rvalid_q <= 1'b1;
        rlast_q  <= r_last;
        rdata_q  <= r_bad ? '0 : mem_q[r_idx];
        rresp_q  <= r_bad ? RESP_SLVERR : RESP_OKAY;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign BUSER   = 1'b0;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RUSER   = 1'b0;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomized bench for axi_slave_mem with a byte-level memory model and per-cycle output compare.
module tb_axi_slave_mem;

  logic        clk, rst;
  logic [0:0]  AWID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR;
  logic [3:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BUSER, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RUSER, RREADY;
  logic [63:0] WDATA, RDATA;
  logic [7:0]  WSTRB;

  axi_slave_mem dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BUSER(BUSER), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RUSER(RUSER),
    .RREADY(RREADY)
  );

  typedef struct packed { logic id; logic [63:0] data; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct packed { logic id; logic [1:0] resp; } bexp_t;

  rbeat_t      exp_r[$];
  bexp_t       exp_b[$];
  logic [63:0] mdl [1024];
  logic [63:0] wdata_a [16];
  logic [7:0]  wstrb_a [16];
  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  int          rd_t [16];
  int          n_vec, n_fail, cyc, t_w, t_b, t_ar, t_rv;
  logic [1:0]  b_got;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_fail++;
    $display("FAIL %s: no handshake within cycle budget", nm);
  endtask

  function automatic bit beat_flag(input logic [31:0] a, input logic [1:0] burst, input logic [2:0] size);
    return !(burst == 2'b00 || burst == 2'b01) || size != 3'd3 || a >= 32'h2000;
  endfunction

  // Per-cycle compare: whenever a response is presented it must match the oldest expected one
  always @(negedge clk) begin
    if (rst) begin
      if (RVALID) begin
        n_vec++;
        if (exp_r.size() == 0) begin
          n_fail++;
          $display("FAIL r_unexpected: RVALID=1 with no beat pending");
        end else begin
          if ({RID, RDATA, RRESP, RLAST} !== exp_r[0]) begin
            n_fail++;
            $display("FAIL r_beat: got id=%0d data=%h resp=%0d last=%0d want id=%0d data=%h resp=%0d last=%0d",
                     RID, RDATA, RRESP, RLAST, exp_r[0].id, exp_r[0].data, exp_r[0].resp, exp_r[0].last);
          end
          if (RREADY) void'(exp_r.pop_front());
        end
      end
      if (BVALID) begin
        n_vec++;
        if (exp_b.size() == 0) begin
          n_fail++;
          $display("FAIL b_unexpected: BVALID=1 with no response pending");
        end else begin
          if ({BID, BRESP} !== exp_b[0]) begin
            n_fail++;
            $display("FAIL b_resp: got id=%0d resp=%0d want id=%0d resp=%0d",
                     BID, BRESP, exp_b[0].id, exp_b[0].resp);
          end
          if (BREADY) void'(exp_b.pop_front());
        end
      end
    end
  end

  task automatic do_write(input logic id, input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input int bad_last, input int prob);
    logic [31:0] a;
    logic        err, flag, lst;
    int          n, beat;
    bit          done;
    a   = addr;
    err = 1'b0;
    for (int b = 0; b <= len; b++) begin
      flag = beat_flag(a, burst, size);
      if (!flag)
        for (int i = 0; i < 8; i++)
          if (wstrb_a[b][i]) mdl[a[12:3]][8*i +: 8] = wdata_a[b][8*i +: 8];
      lst = ((b == len) != (b == bad_last));
      if (flag || lst != (b == len)) err = 1'b1;
      if (burst == 2'b01) a = a + 32'd8;
    end
    exp_b.push_back('{id, err ? 2'd2 : 2'd0});
    t_b = -1;
    AWID = id; AWADDR = addr; AWLEN = 4'(len); AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    n = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk); done = AWREADY;
      @(posedge clk); #1;
      n++;
      if (!done && n > 100) begin timeout("aw_handshake"); AWVALID = 1'b0; return; end
    end
    AWVALID = 1'b0;
    beat = 0; n = 0;
    while (beat <= len) begin
      WVALID = ($urandom_range(99) < prob);
      WDATA  = wdata_a[beat];
      WSTRB  = wstrb_a[beat];
      WLAST  = ((beat == len) != (beat == bad_last));
      @(negedge clk);
      if (WVALID && WREADY) begin t_w = cyc; beat++; end
      @(posedge clk); #1;
      n++;
      if (n > 400) begin timeout("w_handshake"); WVALID = 1'b0; return; end
    end
    WVALID = 1'b0; WLAST = 1'b0;
    n = 0; done = 1'b0;
    while (!done) begin
      BREADY = ($urandom_range(99) < prob);
      @(negedge clk);
      if (BVALID && t_b < 0) t_b = cyc;
      if (BVALID && BREADY) begin done = 1'b1; b_got = BRESP; end
      @(posedge clk); #1;
      n++;
      if (!done && n > 100) begin timeout("b_handshake"); BREADY = 1'b0; return; end
    end
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic id, input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic [2:0] size, input int prob);
    logic [31:0] a;
    logic        flag;
    int          n, beat;
    bit          done;
    a = addr;
    for (int b = 0; b <= len; b++) begin
      flag = beat_flag(a, burst, size);
      exp_r.push_back('{id, flag ? 64'd0 : mdl[a[12:3]], flag ? 2'd2 : 2'd0, (b == len)});
      if (burst == 2'b01) a = a + 32'd8;
    end
    t_rv = -1;
    ARID = id; ARADDR = addr; ARLEN = 4'(len); ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    n = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk); done = ARREADY; t_ar = cyc;
      @(posedge clk); #1;
      n++;
      if (!done && n > 100) begin timeout("ar_handshake"); ARVALID = 1'b0; return; end
    end
    ARVALID = 1'b0;
    beat = 0; n = 0;
    while (beat <= len) begin
      RREADY = ($urandom_range(99) < prob);
      @(negedge clk);
      if (RVALID && t_rv < 0) t_rv = cyc;
      if (RVALID && RREADY) begin
        rd_data[beat] = RDATA; rd_resp[beat] = RRESP; rd_last[beat] = RLAST; rd_t[beat] = cyc;
        beat++;
      end
      @(posedge clk); #1;
      n++;
      if (n > 400) begin timeout("r_handshake"); RREADY = 1'b0; return; end
    end
    RREADY = 1'b0;
  endtask

  int          len, kind, bl, n;
  logic [31:0] addr;
  logic [1:0]  burst;
  logic [2:0]  size;
  logic        id;
  bit          done;

  initial begin
    n_vec = 0; n_fail = 0; cyc = 0;
    rst = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {AWREADY, ARREADY, WREADY}, 64'd0);
    chk("rst_valid", {BVALID, RVALID, RLAST}, 64'd0);
    chk("rst_bresp", {BID, BRESP, BUSER}, 64'd0);
    chk("rst_rside", {RID, RRESP, RUSER}, 64'd0);
    chk("rst_rdata", RDATA, 64'd0);
    rst = 1'b1;
    #1;
    chk("awready_before_edge", AWREADY, 64'd0);
    @(posedge clk); #1;
    chk("awready_after_release", AWREADY, 64'd1);
    chk("arready_after_release", ARREADY, 64'd1);

    // Fill the whole array so the model knows every word
    for (int w = 0; w < 64; w++) begin
      for (int i = 0; i < 16; i++) begin wdata_a[i] = r64(); wstrb_a[i] = 8'hFF; end
      do_write(1'b0, 32'(w * 128), 15, 2'b01, 3'd3, -1, 100);
    end

    // INCR 4-beat write then read back
    for (int i = 0; i < 4; i++) begin wdata_a[i] = 64'(i + 1); wstrb_a[i] = 8'hFF; end
    do_write(1'b1, 32'h40, 3, 2'b01, 3'd3, -1, 100);
    chk("incr_bresp", b_got, 64'd0);
    chk("incr_bvalid_latency", 64'(t_b - t_w), 64'd1);
    do_read(1'b1, 32'h40, 3, 2'b01, 3'd3, 100);
    for (int i = 0; i < 4; i++) chk("incr_rdata", rd_data[i], 64'(i + 1));
    chk("incr_rlast", {rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, 64'b0001);
    chk("incr_first_beat_latency", 64'(t_rv - t_ar), 64'd1);
    chk("incr_back_to_back", 64'(rd_t[3] - rd_t[0]), 64'd3);

    // Partial strobe
    wdata_a[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstrb_a[0] = 8'hFF;
    do_write(1'b0, 32'h0, 0, 2'b01, 3'd3, -1, 100);
    wdata_a[0] = 64'h0; wstrb_a[0] = 8'h0F;
    do_write(1'b0, 32'h0, 0, 2'b01, 3'd3, -1, 100);
    do_read(1'b0, 32'h0, 0, 2'b01, 3'd3, 100);
    chk("partial_strobe", rd_data[0], 64'hFFFF_FFFF_0000_0000);

    // Out of range second beat
    wdata_a[0] = 64'hA5A5_0000_1111_2222; wdata_a[1] = 64'h5A5A_3333_4444_5555;
    wstrb_a[0] = 8'hFF; wstrb_a[1] = 8'hFF;
    do_write(1'b0, 32'h1FF8, 1, 2'b01, 3'd3, -1, 100);
    chk("oor_bresp", b_got, 64'd2);
    do_read(1'b0, 32'h1FF8, 1, 2'b01, 3'd3, 100);
    chk("oor_rresp0", rd_resp[0], 64'd0);
    chk("oor_rresp1", rd_resp[1], 64'd2);
    chk("oor_rdata0", rd_data[0], 64'hA5A5_0000_1111_2222);
    chk("oor_rdata1", rd_data[1], 64'd0);

    // Concurrent write and backpressured read
    for (int i = 0; i < 4; i++) begin wdata_a[i] = r64(); wstrb_a[i] = 8'hFF; end
    fork
      do_write(1'b1, 32'h200, 3, 2'b01, 3'd3, -1, 80);
      do_read(1'b0, 32'h1000, 7, 2'b01, 3'd3, 50);
    join
    chk("concurrent_bresp", b_got, 64'd0);
    chk("concurrent_r_drained", 64'(exp_r.size()), 64'd0);

    // WRAP write leaves memory untouched
    wdata_a[0] = r64(); wdata_a[1] = r64(); wstrb_a[0] = 8'hFF; wstrb_a[1] = 8'hFF;
    do_write(1'b0, 32'h300, 1, 2'b10, 3'd3, -1, 100);
    chk("wrap_bresp", b_got, 64'd2);
    do_read(1'b0, 32'h300, 1, 2'b01, 3'd3, 100);

    // Early WLAST still accepts the second beat
    wdata_a[0] = 64'h1234_5678_9ABC_DEF0; wdata_a[1] = 64'h0FED_CBA9_8765_4321;
    do_write(1'b1, 32'h400, 1, 2'b01, 3'd3, 0, 100);
    chk("early_wlast_bresp", b_got, 64'd2);
    do_read(1'b0, 32'h400, 1, 2'b01, 3'd3, 100);
    chk("early_wlast_beat2", rd_data[1], 64'h0FED_CBA9_8765_4321);

    // Reset in the middle of a read
    for (int b = 0; b < 4; b++) exp_r.push_back('{1'b0, mdl[256 + b], 2'd0, (b == 3)});
    ARID = 1'b0; ARADDR = 32'h800; ARLEN = 4'd3; ARSIZE = 3'd3; ARBURST = 2'b01; ARVALID = 1'b1;
    RREADY = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk); done = ARREADY;
      @(posedge clk); #1; n++;
    end
    ARVALID = 1'b0;
    if (!done) timeout("reset_ar");
    n = 0; done = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk); done = RVALID && RREADY;
      @(posedge clk); #1; n++;
    end
    if (!done) timeout("reset_first_beat");
    rst = 1'b0;
    #1;
    chk("reset_rvalid", RVALID, 64'd0);
    chk("reset_arready", ARREADY, 64'd0);
    exp_r.delete();
    RREADY = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("reset_arready_pre_edge", ARREADY, 64'd0);
    @(posedge clk); #1;
    chk("reset_arready_post_edge", ARREADY, 64'd1);
    do_read(1'b0, 32'h800, 3, 2'b01, 3'd3, 100);

    // Randomized bursts, some concurrent on disjoint halves
    for (int it = 0; it < 40; it++) begin
      kind  = $urandom_range(9);
      len   = $urandom_range(15);
      id    = 1'($urandom_range(1));
      burst = (kind == 0) ? 2'($urandom_range(2, 3)) : ($urandom_range(1) ? 2'b01 : 2'b00);
      size  = (kind == 1) ? 3'd2 : 3'd3;
      bl    = (kind == 2) ? $urandom_range(len) : -1;
      for (int i = 0; i < 16; i++) begin wdata_a[i] = r64(); wstrb_a[i] = 8'($urandom); end
      if (kind < 7) begin
        addr = $urandom_range(0, 32'h2100);
        do_write(id, addr, len, burst, size, bl, 75);
        do_read(~id, addr, len, ($urandom_range(7) == 0) ? 2'b10 : 2'b01, 3'd3, 70);
      end else begin
        addr = $urandom_range(0, 32'hF00);
        fork
          do_write(id, addr, len, burst, size, bl, 60);
          do_read(id, 32'h1000 + $urandom_range(0, 32'h1100), $urandom_range(15), 2'b01, 3'd3, 60);
        join
        do_read(id, addr, len, 2'b01, 3'd3, 90);
      end
    end

    repeat (4) @(posedge clk);
    chk("r_queue_empty", 64'(exp_r.size()), 64'd0);
    chk("b_queue_empty", 64'(exp_b.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

AXI4 slave (responder) memory that terminates the `axi_if` bundle driven by the accelerator's AXI masters. It services independent read and write bursts against an internal word-addressed array. It is used as the DDR stand-in in block-level benches and as an on-chip scratch buffer in FPGA builds. The read and write channels run concurrently, each with its own FSM.

## Interface
Parameters:
- ADDR_WIDTH, 32: AxADDR width.
- STRB_WIDTH, 8: bytes per beat; data width is STRB_WIDTH*8.
- LEN_WIDTH, 4: AxLEN width; max burst is 2**LEN_WIDTH beats.
- SIZE_WIDTH, 3: AxSIZE width.
- ID_WIDTH, 1: ID width.
- MEM_DEPTH, 1024: array depth in beats; power of two.
- BASE_ADDR, 0: byte address of word 0; aligned to MEM_DEPTH*STRB_WIDTH.

Ports (clock and reset first; channel signals grouped, per-signal widths match `axi_if`):
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  input  ID/ADDR/LEN/SIZE/2/1  write address; AWLOCK/CACHE/PROT/QOS/REGION/USER accepted, ignored.
- AWREADY  output  1  write address accept.
- WDATA/WSTRB/WLAST/WVALID  input  STRB_WIDTH*8/STRB_WIDTH/1/1  write data; WID, WUSER ignored.
- WREADY  output  1  write data accept.
- BID/BRESP/BVALID/BUSER  output  ID/2/1/1  write response.
- BREADY  input  1  response accept.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  input  as AW  read address; other AR sidebands ignored.
- ARREADY  output  1  read address accept.
- RID/RDATA/RRESP/RLAST/RVALID/RUSER  output  ID/STRB_WIDTH*8/2/1/1/1  read data.
- RREADY  input  1  read data accept.

## Operation
- Write FSM: W_IDLE -> W_DATA (on AW handshake) -> W_RESP (on final W handshake) -> W_IDLE (on B handshake).
  - AWREADY=1 only in W_IDLE; WREADY=1 only in W_DATA; BVALID=1 only in W_RESP.
  - The AW handshake latches ID, address, LEN, BURST and clears the beat counter and error flag.
- Read FSM: R_IDLE -> R_DATA (on AR handshake) -> R_IDLE (on R handshake with RLAST=1).
  - ARREADY=1 only in R_IDLE.
- Address generation:
  - INCR: +STRB_WIDTH per beat.
  - FIXED: address constant.
  - WRAP or reserved BURST: every beat flagged as an error, no memory write.
  - Word index = (addr-BASE_ADDR)>>log2(STRB_WIDTH). Low address bits are ignored, so unaligned starts are treated as aligned.
  - No 4 KB boundary check.
- Error conditions:
  - Any beat whose address is outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*STRB_WIDTH) is out of range.
  - AxSIZE != log2(STRB_WIDTH) flags the whole burst.
  - On a flagged write beat, the write is suppressed.
  - On a flagged read beat, RDATA=0 and RRESP=SLVERR(2).
- Writes: byte lane i is written when WSTRB[i]=1.
- Burst end: the burst ends after exactly LEN+1 beats. A WLAST value that disagrees with the beat count on any beat sets the error flag; data continues to be accepted.
- BRESP: SLVERR if any beat of the burst was flagged, else OKAY(0). BID = latched AWID.
- RID = latched ARID. RLAST=1 on beat LEN+1. BUSER=RUSER=0.
- Same-cycle read and write to the same word: the read loads the old contents (the write commits at the edge).

## Timing
- Reset values: AWREADY=ARREADY=WREADY=BVALID=RVALID=RLAST=0; BID, BRESP, RID, RRESP, RDATA=0.
  - AWREADY and ARREADY are registers that rise on the first clk edge after rst deasserts.
  - The memory array is not reset.
- Reset asserted mid-burst: both FSMs return to IDLE immediately and the burst is abandoned. Beats already written remain in memory.
- Write path:
  - First WREADY in the cycle after the AW handshake.
  - BVALID in the cycle after the last W handshake.
  - Next AWREADY in the cycle after the B handshake.
  - Best case for a single-beat write is 3 cycles per burst.
- Read path:
  - RDATA/RVALID are registered. The first beat is valid in the cycle after the AR handshake.
  - Each R handshake on a non-last beat loads the next beat at that edge, so RREADY held high gives one beat per cycle.
  - RVALID, RDATA, RRESP, RLAST and RID hold stable while RREADY=0.
- Once BVALID or RVALID is asserted, it stays asserted until its handshake completes.

## Structure
- Shared `axi_pkg`: BURST encodings (FIXED/INCR/WRAP), RESP encodings (OKAY/EXOKAY/SLVERR/DECERR), `w_state_t` and `r_state_t` enums.
- Sub-module `axi_burst_addr`, instantiated once per channel: latches start address/LEN/BURST/SIZE, steps on each beat, and outputs word index, in-range flag, last-beat flag and error flag.
- Memory array is a local two-port register array: one write port and one combinational read port.

## Test plan
- INCR write: AWADDR=0x40, AWLEN=3, WSTRB=0xFF, data 1..4. Expect BRESP=OKAY one cycle after the 4th beat. Then ARADDR=0x40, ARLEN=3 with RREADY=1: RDATA 1,2,3,4 on consecutive cycles, RLAST on the 4th.
- Partial strobe: word 0 holds 0xFFFF_FFFF_FFFF_FFFF; write 0 with WSTRB=0x0F. Readback = 0xFFFF_FFFF_0000_0000.
- Out of range: with MEM_DEPTH=1024, AWADDR=0x1FF8, AWLEN=1. Beat 1 is written, beat 2 is dropped, BRESP=SLVERR. Reading the same burst returns RRESP OKAY then SLVERR, with RDATA=0 on beat 2.
- Backpressure and concurrency: toggle RREADY randomly during an 8-beat read while a 4-beat write runs. RDATA is stable while stalled, all 8 beats arrive in order, and the write completes independently.
- Protocol errors: AWBURST=WRAP gives SLVERR and no memory change. AWLEN=1 with WLAST on beat 1 gives SLVERR, and the second beat is still accepted.
- Reset mid-read: assert rst on beat 2 of a 4-beat read. RVALID=0 at once, ARREADY=1 on the first edge after release, and memory contents are unchanged.
